// File: rtl/radio_stream_time_probe_if.sv
// Per-channel AXI-stream bundle used on both sides of the time probe.
// Channel i occupies tdata[32i+31:32i], tuser[128i+127:128i] and bit i of the sidebands.
interface radio_stream_time_probe_if #(
  parameter int NUM_CHANNELS = 2
);
  logic [32*NUM_CHANNELS-1:0]  tdata;
  logic [128*NUM_CHANNELS-1:0] tuser;
  logic [NUM_CHANNELS-1:0]     tlast;
  logic [NUM_CHANNELS-1:0]     tvalid;
  logic [NUM_CHANNELS-1:0]     tready;

  modport master (output tdata, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/radio_stream_time_probe.sv
// Per-channel stream probe: skid-buffered pass-through with VITA-time / beat-count substitution,
// packet/elapsed measurement and settings/readback access. Optional max-gap tracking: PROBE_MAX_GAP_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | counters held at zero, waiting for an arm command
// ST_ARMED   | waiting for the first output tlast handshake to start timing
// ST_RUNNING | elapsed counts every cycle, pkt_count counts output tlasts
module radio_stream_time_probe #(
  parameter int         NUM_CHANNELS  = 2,
  parameter int         CNT_W         = 32,
  parameter logic [7:0] SR_PROBE_BASE = 8'd200,
  parameter logic [7:0] RB_PROBE_BASE = 8'd64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [63:0]                      vita_time,
  input  logic                             set_stb,
  input  logic [7:0]                       set_addr,
  input  logic [31:0]                      set_data,
  input  logic                             rb_req,
  input  logic [7:0]                       rb_addr,
  output logic                             rb_stb,
  output logic [63:0]                      rb_data,
  radio_stream_time_probe_if.slave         s_axis,
  radio_stream_time_probe_if.master        m_axis
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RUNNING = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CHANNELS-1:0][3:0][63:0] rb_val;
  logic [NUM_CHANNELS-1:0]            in_rdy_v;
  logic [NUM_CHANNELS-1:0]            out_vld_v;
  logic [NUM_CHANNELS-1:0]            out_last_v;
  logic [32*NUM_CHANNELS-1:0]         out_data_v;
  logic [128*NUM_CHANNELS-1:0]        out_user_v;
  logic [63:0]                        rb_mux;
  logic                               unused_set_bits;

  assign unused_set_bits = ^set_data[31:8];

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
    localparam logic [7:0] CTRL_ADDR = SR_PROBE_BASE + 8'(2*ch);
    localparam logic [7:0] CMD_ADDR  = SR_PROBE_BASE + 8'(2*ch + 1);

    logic [7:0]       ctrl_q;
    logic [31:0]      beat_cnt_q;
    logic             clr;
    logic             arm;
    logic             in_hs;
    logic             out_rdy;
    logic             out_hs;
    logic             out_last_hs;
    logic [31:0]      tdata_i;
    logic [127:0]     tuser_i;
    logic [31:0]      vt_word;
    logic [31:0]      sub_data;
    logic [160:0]     beat_in;
    logic             main_vld_q;
    logic             skid_vld_q;
    logic [160:0]     main_q;
    logic [160:0]     skid_q;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] pkt_q;
    logic [CNT_W-1:0] pkt_d;
    logic [CNT_W-1:0] elap_q;
    logic [CNT_W-1:0] elap_d;
    logic [CNT_W-1:0] max_gap;

    // clear dominates arm when both command bits arrive together
    assign clr = set_stb && (set_addr == CMD_ADDR) && set_data[0];
    assign arm = set_stb && (set_addr == CMD_ADDR) && set_data[1] && !set_data[0];

    assign tdata_i     = s_axis.tdata[32*ch +: 32];
    assign tuser_i     = s_axis.tuser[128*ch +: 128];
    assign in_hs       = s_axis.tvalid[ch] && !skid_vld_q;
    assign out_rdy     = m_axis.tready[ch];
    assign out_hs      = main_vld_q && out_rdy;
    assign out_last_hs = out_hs && main_q[0];

    always_comb begin
      vt_word = ctrl_q[2] ? vita_time[63:32] : vita_time[31:0];
      case (ctrl_q[1:0])
        2'd1:    sub_data = vt_word;
        2'd2:    sub_data = (tuser_i[127:124] == ctrl_q[7:4]) ? vt_word : tdata_i;
        2'd3:    sub_data = beat_cnt_q;
        default: sub_data = tdata_i;
      endcase
    end

    assign beat_in = {sub_data, tuser_i, s_axis.tlast[ch]};

    always_ff @(posedge clk) begin
      if (reset) begin
        ctrl_q <= 8'd0;
      end else if (set_stb && (set_addr == CTRL_ADDR)) begin
        ctrl_q <= set_data[7:0];
      end
    end

    always_ff @(posedge clk) begin
      if (reset || clr) begin
        beat_cnt_q <= 32'd0;
      end else if (in_hs) begin
        beat_cnt_q <= beat_cnt_q + 32'd1;
      end
    end

    // ready is simply "skid slot free", so it only drops with both entries occupied
    always_ff @(posedge clk) begin
      if (reset) begin
        main_vld_q <= 1'b0;
        skid_vld_q <= 1'b0;
      end else if (!main_vld_q || out_rdy) begin
        main_vld_q <= skid_vld_q || in_hs;
        skid_vld_q <= 1'b0;
      end else if (in_hs) begin
        skid_vld_q <= 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!main_vld_q || out_rdy) begin
        if (skid_vld_q) begin
          main_q <= skid_q;
        end else if (in_hs) begin
          main_q <= beat_in;
        end
      end else if (in_hs) begin
        skid_q <= beat_in;
      end
    end

    assign in_rdy_v[ch]             = !skid_vld_q;
    assign out_vld_v[ch]            = main_vld_q;
    assign out_last_v[ch]           = main_q[0];
    assign out_data_v[32*ch +: 32]  = main_q[160:129];
    assign out_user_v[128*ch +: 128] = main_q[128:1];

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= ST_IDLE;
        pkt_q   <= '0;
        elap_q  <= '0;
      end else begin
        state_q <= state_d;
        pkt_q   <= pkt_d;
        elap_q  <= elap_d;
      end
    end

    always_comb begin
      state_d = state_q;
      pkt_d   = pkt_q;
      elap_d  = elap_q;
      case (state_q)
        ST_IDLE: begin
          if (arm) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (out_last_hs) begin
            state_d = ST_RUNNING;
            elap_d  = '0;
            pkt_d   = CNT_W'(1);
          end
        end
        ST_RUNNING: begin
          if (elap_q != CNT_MAX) elap_d = elap_q + 1'b1;
          if (out_last_hs && (pkt_q != CNT_MAX)) pkt_d = pkt_q + 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
      if (clr) begin
        state_d = ST_IDLE;
        pkt_d   = '0;
        elap_d  = '0;
      end
    end

`ifdef PROBE_MAX_GAP_EN
    logic             in_pkt_q;
    logic [CNT_W-1:0] gap_cur_q;
    logic [CNT_W-1:0] gap_max_q;
    logic [CNT_W-1:0] gap_inc;

    assign gap_inc = (gap_cur_q == CNT_MAX) ? gap_cur_q : gap_cur_q + 1'b1;

    // a gap is a run of out_tvalid=0 cycles following a non-last output beat
    always_ff @(posedge clk) begin
      if (reset || clr) begin
        in_pkt_q  <= 1'b0;
        gap_cur_q <= '0;
        gap_max_q <= '0;
      end else begin
        if (out_hs) in_pkt_q <= !main_q[0];
        if (main_vld_q) begin
          gap_cur_q <= '0;
        end else if (in_pkt_q && (state_q == ST_RUNNING)) begin
          gap_cur_q <= gap_inc;
          if (gap_inc > gap_max_q) gap_max_q <= gap_inc;
        end
      end
    end

    assign max_gap = gap_max_q;
`else
    assign max_gap = '0;
`endif

    assign rb_val[ch][0] = 64'(pkt_q);
    assign rb_val[ch][1] = 64'(elap_q);
    assign rb_val[ch][2] = {30'd0, state_q, 24'd0, ctrl_q};
    assign rb_val[ch][3] = 64'(max_gap);
  end

  assign s_axis.tready = in_rdy_v;
  assign m_axis.tvalid = out_vld_v;
  assign m_axis.tlast  = out_last_v;
  assign m_axis.tdata  = out_data_v;
  assign m_axis.tuser  = out_user_v;

  always_comb begin
    rb_mux = 64'd0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      for (int k = 0; k < 4; k++) begin
        if (rb_addr == RB_PROBE_BASE + 8'(4*ch + k)) rb_mux = rb_val[ch][k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rb_stb  <= 1'b0;
      rb_data <= 64'd0;
    end else begin
      rb_stb <= rb_req;
      if (rb_req) rb_data <= rb_mux;
    end
  end

endmodule

// File: tb/tb_radio_stream_time_probe.sv
// Directed bench for radio_stream_time_probe: scoreboarded stream checks plus readback checks.
// Built with CNT_W=8 so elapsed saturation is reachable in a few hundred cycles.
module tb_radio_stream_time_probe;
  localparam int         NCH = 2;
  localparam int         CW  = 8;
  localparam logic [7:0] SRB = 8'd200;
  localparam logic [7:0] RBB = 8'd64;

  typedef struct packed {
    logic [31:0]  d;
    logic [127:0] u;
    logic         l;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] vita_time;
  logic [63:0] vt_base;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic        rb_req;
  logic [7:0]  rb_addr;
  logic        rb_stb;
  logic [63:0] rb_data;

  radio_stream_time_probe_if #(.NUM_CHANNELS(NCH)) in_if ();
  radio_stream_time_probe_if #(.NUM_CHANNELS(NCH)) out_if ();

  radio_stream_time_probe #(
    .NUM_CHANNELS (NCH),
    .CNT_W        (CW),
    .SR_PROBE_BASE(SRB),
    .RB_PROBE_BASE(RBB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .vita_time(vita_time),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data),
    .rb_req   (rb_req),
    .rb_addr  (rb_addr),
    .rb_stb   (rb_stb),
    .rb_data  (rb_data),
    .s_axis   (in_if),
    .m_axis   (out_if)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         ordy_mode = 0;
  beat_t      sb0[$];
  beat_t      sb1[$];
  logic [7:0] ctrl_m [NCH];
  logic [31:0] bcnt_m [NCH];
  int         tlast_cnt [NCH];
  int         tlast_cyc [NCH];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int ch);
    beat_t       b;
    logic [31:0] vw;
    b.d = in_if.tdata[32*ch +: 32];
    b.u = in_if.tuser[128*ch +: 128];
    b.l = in_if.tlast[ch];
    vw  = ctrl_m[ch][2] ? vita_time[63:32] : vita_time[31:0];
    case (ctrl_m[ch][1:0])
      2'd1: b.d = vw;
      2'd2: if (b.u[127:124] == ctrl_m[ch][7:4]) b.d = vw;
      2'd3: b.d = bcnt_m[ch];
      default: ;
    endcase
    bcnt_m[ch] = bcnt_m[ch] + 32'd1;
    if (ch == 0) sb0.push_back(b);
    else         sb1.push_back(b);
  endtask

  task automatic pop_cmp(input int ch);
    beat_t got;
    beat_t exp;
    got = {out_if.tdata[32*ch +: 32], out_if.tuser[128*ch +: 128], out_if.tlast[ch]};
    if (got.l) begin
      tlast_cnt[ch]++;
      if (tlast_cnt[ch] == 1) tlast_cyc[ch] = cyc;
    end
    exp = 'x;
    if (ch == 0 && sb0.size() > 0) exp = sb0.pop_front();
    if (ch == 1 && sb1.size() > 0) exp = sb1.pop_front();
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL beat_ch%0d got d=%h u=%h l=%b expected d=%h u=%h l=%b",
             ch, got.d, got.u, got.l, exp.d, exp.u, exp.l);
    end
  endtask

  // one clock: sample handshakes at negedge, then step past the posedge and refresh drivers
  task automatic tick();
    @(negedge clk);
    if (!reset) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (in_if.tvalid[ch] && in_if.tready[ch]) push_exp(ch);
        if (out_if.tvalid[ch] && out_if.tready[ch]) pop_cmp(ch);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    vita_time = vt_base + 64'(cyc);
    for (int ch = 0; ch < NCH; ch++)
      out_if.tready[ch] = (ordy_mode == 1) ? 1'($urandom_range(0, 1)) : (ordy_mode == 0);
  endtask

  task automatic set_ordy(input int m);
    ordy_mode = m;
    for (int ch = 0; ch < NCH; ch++) out_if.tready[ch] = (m != 2);
  endtask

  task automatic set_vt(input logic [63:0] at_now);
    vt_base   = at_now - 64'(cyc);
    vita_time = vt_base + 64'(cyc);
  endtask

  task automatic send_beat(input int ch, input logic [31:0] d, input logic [127:0] u, input logic l);
    int n = 0;
    in_if.tvalid[ch]           = 1'b1;
    in_if.tdata[32*ch +: 32]   = d;
    in_if.tuser[128*ch +: 128] = u;
    in_if.tlast[ch]            = l;
    while (!in_if.tready[ch] && n < 200) begin
      tick();
      n++;
    end
    total++;
    assert (n < 200) else begin
      bad++;
      $error("FAIL beat_accept_timeout ch%0d got=%0d cycles expected<200", ch, n);
    end
    tick();
    in_if.tvalid[ch] = 1'b0;
    in_if.tlast[ch]  = 1'b0;
  endtask

  task automatic send_pkt(input int ch, input int nb, input logic [31:0] start, input logic [3:0] typ);
    for (int i = 0; i < nb; i++)
      send_beat(ch, start + 32'(i), {typ, 28'd0, 32'(ch), start, 32'(i)}, i == nb - 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && n < 1000) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk("drain_empty", 64'(sb0.size() + sb1.size()), 64'd0);
  endtask

  task automatic sr_write(input logic [7:0] a, input logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = a;
    set_data = d;
    tick();
    set_stb = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (a == SRB + 8'(2*ch)) ctrl_m[ch] = d[7:0];
      if (a == SRB + 8'(2*ch + 1) && d[0]) bcnt_m[ch] = 32'd0;
    end
  endtask

  task automatic rb_read(input logic [7:0] a, input string tag, input logic [63:0] exp);
    rb_req  = 1'b1;
    rb_addr = a;
    tick();
    rb_req = 1'b0;
    chk({tag, "_stb"}, 64'(rb_stb), 64'd1);
    chk(tag, rb_data, exp);
  endtask

  task automatic rb_all_zero(input string tag);
    for (int ch = 0; ch < NCH; ch++)
      for (int k = 0; k < 4; k++)
        rb_read(RBB + 8'(4*ch + k), tag, 64'd0);
  endtask

  task automatic model_reset();
    sb0.delete();
    sb1.delete();
    for (int ch = 0; ch < NCH; ch++) begin
      ctrl_m[ch]    = 8'd0;
      bcnt_m[ch]    = 32'd0;
      tlast_cnt[ch] = 0;
      tlast_cyc[ch] = 0;
    end
  endtask

  initial begin
    int          t0;
    int          n;
    logic [63:0] exp_el;
    logic [63:0] exp_gap;

    reset         = 1'b1;
    set_stb       = 1'b0;
    set_addr      = 8'd0;
    set_data      = 32'd0;
    rb_req        = 1'b0;
    rb_addr       = 8'd0;
    in_if.tvalid  = '0;
    in_if.tlast   = '0;
    in_if.tdata   = '0;
    in_if.tuser   = '0;
    out_if.tready = '1;
    vt_base       = 64'd0;
    vita_time     = 64'd0;
    model_reset();

    repeat (3) tick();
    chk("rst_out_tvalid", 64'(out_if.tvalid), 64'd0);
    chk("rst_in_tready", 64'(in_if.tready), 64'h3);
    chk("rst_rb_stb", 64'(rb_stb), 64'd0);
    chk("rst_rb_data", rb_data, 64'd0);
    reset = 1'b0;
    tick();
    rb_all_zero("rst_rb");

    // PASS, random backpressure
    set_ordy(1);
    for (int p = 0; p < 3; p++) send_pkt(0, 4, 32'(4*p + 1), 4'h0);
    drain();

    // TIME, upper word
    sr_write(SRB, 32'h0000_0005);
    set_vt(64'h0000_00AB_0000_0010);
    send_pkt(0, 4, 32'h0000_0100, 4'h1);
    drain();

    // MATCH type 2, lower word
    sr_write(SRB, 32'h0000_0022);
    set_vt(64'h0000_0000_0000_0100);
    for (int p = 0; p < 4; p++) send_pkt(0, 3, 32'h0000_0200 + 32'(16*p), (p % 2 == 0) ? 4'h2 : 4'h0);
    drain();

    // COUNT after clear
    sr_write(SRB + 8'd1, 32'h1);
    sr_write(SRB, 32'h0000_0003);
    send_pkt(0, 3, 32'h0000_0300, 4'h3);
    send_pkt(0, 3, 32'h0000_0310, 4'h3);
    drain();
    rb_read(RBB + 8'd2, "ch0_ctrl_idle", 64'h0000_0000_0000_0003);

    // measurement on ch1
    set_ordy(0);
    sr_write(SRB + 8'd3, 32'h2);
    rb_read(RBB + 8'd6, "ch1_armed", 64'h0000_0001_0000_0000);
    tlast_cnt[1] = 0;
    for (int p = 0; p < 5; p++) send_pkt(1, 2, 32'h0000_0400 + 32'(8*p), 4'h0);
    drain();
    t0 = tlast_cyc[1];
    n  = 0;
    while (cyc < t0 + 51 && n < 300) begin
      tick();
      n++;
    end
    exp_el = 64'(cyc - t0 - 1);
    rb_read(RBB + 8'd5, "ch1_elapsed", exp_el);
    rb_read(RBB + 8'd4, "ch1_pkt_count", 64'd5);
    rb_read(RBB + 8'd6, "ch1_running", 64'h0000_0002_0000_0000);
    sr_write(SRB + 8'd3, 32'h3);
    rb_read(RBB + 8'd6, "ch1_clr_arm_state", 64'd0);
    rb_read(RBB + 8'd4, "ch1_clr_pkt", 64'd0);
    rb_read(RBB + 8'd5, "ch1_clr_elapsed", 64'd0);

    // elapsed saturation at CNT_W=8
    sr_write(SRB + 8'd3, 32'h2);
    send_pkt(1, 2, 32'h0000_0500, 4'h0);
    drain();
    repeat (300) tick();
    rb_read(RBB + 8'd5, "ch1_elapsed_sat", 64'h0000_0000_0000_00FF);
    rb_read(RBB + 8'd4, "ch1_sat_pkt", 64'd1);
    sr_write(SRB + 8'd3, 32'h2);
    rb_read(RBB + 8'd6, "ch1_arm_ignored", 64'h0000_0002_0000_0000);

    // intra-packet gaps of 7 then 3 on ch0
    sr_write(SRB, 32'h0);
    sr_write(SRB + 8'd1, 32'h1);
    sr_write(SRB + 8'd1, 32'h2);
    send_pkt(0, 1, 32'h0000_0600, 4'h0);
    send_beat(0, 32'h0000_0610, 128'h10, 1'b0);
    repeat (7) tick();
    send_beat(0, 32'h0000_0611, 128'h11, 1'b0);
    repeat (3) tick();
    send_beat(0, 32'h0000_0612, 128'h12, 1'b1);
    drain();
`ifdef PROBE_MAX_GAP_EN
    exp_gap = 64'd7;
`else
    exp_gap = 64'd0;
`endif
    rb_read(RBB + 8'd3, "ch0_max_gap", exp_gap);
    rb_read(RBB + 8'd0, "ch0_gap_pkt", 64'd2);

    // out-of-range channel addresses
    sr_write(SRB + 8'd4, 32'hFF);
    sr_write(SRB + 8'd5, 32'h1);
    rb_read(RBB + 8'd2, "ch0_after_bad_sr", 64'h0000_0002_0000_0000);
    rb_read(RBB + 8'd6, "ch1_after_bad_sr", 64'h0000_0002_0000_0000);
    rb_read(RBB + 8'd8, "rb_unmapped_ch2", 64'd0);
    rb_read(8'd0, "rb_unmapped_0", 64'd0);

    // back-to-back readback requests
    rb_req  = 1'b1;
    rb_addr = RBB + 8'd0;
    tick();
    chk("b2b_stb0", 64'(rb_stb), 64'd1);
    chk("b2b_data0", rb_data, 64'd2);
    rb_addr = RBB + 8'd5;
    tick();
    rb_req = 1'b0;
    chk("b2b_stb1", 64'(rb_stb), 64'd1);
    chk("b2b_data1", rb_data, 64'h0000_0000_0000_00FF);
    tick();
    chk("b2b_stb_low", 64'(rb_stb), 64'd0);
    chk("b2b_data_held", rb_data, 64'h0000_0000_0000_00FF);

    // reset with both skid entries full mid-packet
    sr_write(SRB, 32'h1);
    set_ordy(2);
    send_beat(0, 32'h0000_0700, 128'h20, 1'b0);
    send_beat(0, 32'h0000_0701, 128'h21, 1'b0);
    chk("full_in_tready", 64'(in_if.tready[0]), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    chk("midrst_out_tvalid", 64'(out_if.tvalid), 64'd0);
    chk("midrst_in_tready", 64'(in_if.tready), 64'h3);
    set_ordy(0);
    rb_all_zero("midrst_rb");
    send_pkt(0, 2, 32'h0000_0800, 4'h0);
    send_pkt(1, 2, 32'h0000_0900, 4'h0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
